// File: rtl/booth_pkg.sv
// Shared types and constants for the
// shared sequential Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  localparam int WIDTH_DEF = 4;
  localparam int NREQ_DEF  = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/booth_mult_sched_step.sv
// One radix-2 Booth step: add/sub x into
// acc, then arithmetic shift of {acc,y,q}.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             q_i,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] y_o,
  output logic             q_o
);

  logic [WIDTH:0]     xs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH+1:0] p;

  assign xs = {x_i[WIDTH-1], x_i};

  // Booth recoding of the current bit pair
  always_comb begin
    sum = acc_i;
    unique case (1'b1)
      ({y_i[0], q_i} == 2'b01): sum = acc_i + xs;
      ({y_i[0], q_i} == 2'b10): sum = acc_i - xs;
      default:                  sum = acc_i;
    endcase
  end

  assign p = {sum, y_i, q_i};
  assign {acc_o, y_o, q_o} = {sum[WIDTH], p[2*WIDTH+1:1]};

endmodule

// File: rtl/booth_mult_sched.sv
// Round-robin scheduler sharing one
// sequential Booth multiplier.
module booth_mult_sched
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int IDW   = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [2*WIDTH-1:0]    resp_prod,
  output logic [IDW-1:0]        resp_id,
  output logic                  busy
);

  localparam int CW = clog2(WIDTH + 1);

  state_e             state_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     acc_q;
  logic [WIDTH-1:0]   y_q;
  logic               q_q;
  logic [WIDTH-1:0]   x_q;
  logic [IDW-1:0]     id_q;
  logic               resp_valid_q;
  logic [2*WIDTH-1:0] resp_prod_q;
  logic [IDW-1:0]     resp_id_q;

  logic [WIDTH:0]     acc_d;
  logic [WIDTH-1:0]   y_d;
  logic               q_d;

  logic               gnt_found;
  logic [IDW-1:0]     gnt_idx;
  logic [IDW-1:0]     ptr_d;
  logic               accept;

  // First valid requester at or after rr_ptr
  always_comb begin
    int j;
    j = 0;
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

  assign accept = rst_n && (state_q == IDLE)
                  && gnt_found;

  assign ptr_d = (gnt_idx == IDW'(NREQ - 1))
               ? '0 : gnt_idx + IDW'(1);

  // One-hot accept, only while idle
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i(acc_q),
    .y_i  (y_q),
    .q_i  (q_q),
    .x_i  (x_q),
    .acc_o(acc_d),
    .y_o  (y_d),
    .q_o  (q_d)
  );

  // Scheduler FSM with datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      y_q          <= '0;
      q_q          <= 1'b0;
      x_q          <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_prod_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            x_q      <= req_x[int'(gnt_idx)*WIDTH +: WIDTH];
            y_q      <= req_y[int'(gnt_idx)*WIDTH +: WIDTH];
            acc_q    <= '0;
            q_q      <= 1'b0;
            id_q     <= gnt_idx;
            rr_ptr_q <= ptr_d;
            cnt_q    <= '0;
            state_q  <= ITER;
          end
        end
        ITER: begin
          acc_q <= acc_d;
          y_q   <= y_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            resp_prod_q  <= {acc_d[WIDTH-1:0], y_d};
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_prod  = resp_prod_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);

endmodule
